fence_t_sequencer: RTL and testbench
====================================

FENCE_T_SEQUENCER -- requirements
Module: fence_t_sequencer

Interface
REQ-001 SHALL have parameter PadCntWidth, default 16, width of the padding target and the elapsed-cycle counter.
REQ-002 SHALL have port clk_i, input, 1, the single clock.
REQ-003 SHALL have port rst_i, input, 1, reset; one clock, reset is asynchronous and active-high.
REQ-004 SHALL have port fence_t_valid_i, input, 1, fence.t request from commit.
REQ-005 SHALL have port fence_t_ready_o, output, 1, request accepted when valid and ready are both high.
REQ-006 SHALL have port fence_t_sel_i, input, FENCE_T_W (11), selects which microarchitectural state is flushed.
REQ-007 SHALL have port fence_t_pad_i, input, PadCntWidth, the constant-time padding target in cycles.
REQ-008 SHALL have port flush_dcache_ack_i, input, 1, DCache flush complete.
REQ-009 SHALL have port fence_t_o, output, FENCE_T_W, per-resource flush strobes to the flush controller.
REQ-010 SHALL have port halt_o, output, 1, stalls commit while a fence.t is in progress.
REQ-011 SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port overrun_o, output, 1, qualified by done_o; flush work exceeded the padding target.

Function
REQ-013 SHALL implement FSM states IDLE, DCACHE, FLUSH, PAD, DONE.
REQ-014 SHALL assert fence_t_ready_o only in IDLE.
REQ-015 SHALL, on acceptance, latch sel_q and pad_q, clear cnt_q to 0, and go to DCACHE if sel_i[4] is set, else to FLUSH.
REQ-016 SHALL increment cnt_q every cycle in non-IDLE states and saturate it at all-ones; the first busy cycle sees cnt_q=0.
REQ-017 SHALL, in DCACHE, drive fence_t_o[4]=1 every cycle and move to FLUSH in the cycle after flush_dcache_ack_i is sampled high.
REQ-018 SHALL, in FLUSH, drive fence_t_o = sel_q with bit 4 masked for exactly one cycle.
REQ-019 SHALL, from FLUSH or PAD, go to DONE when cnt_q >= pad_q; otherwise it goes or stays in PAD with fence_t_o=0.
REQ-020 SHALL, in DONE, pulse done_o for one cycle, set overrun_o if cnt_q at FLUSH exit was > pad_q, and then return to IDLE.
REQ-021 SHALL drive halt_o = (state != IDLE).
REQ-022 SHALL ignore fence_t_valid_i in all non-IDLE states, including DONE; no request queueing.
REQ-023 SHALL handle sel_i=0 by running the normal path with all-zero strobes, so padding still applies.
REQ-024 SHALL keep fence_t_o at 0 in IDLE, PAD and DONE.

Reset
REQ-025 SHALL, on rst_i, go to IDLE immediately with cnt_q=0, sel_q=0, pad_q=0, and all outputs 0 except fence_t_ready_o=1.
REQ-026 SHALL, on reset mid-operation, abandon any pending DCache flush without waiting for the ack; a late ack in IDLE is ignored.

Configuration
REQ-027 SHALL gate padding with macro FENCE_T_PAD_EN. When defined: PAD state and the padding rules above apply. When undefined: FLUSH goes directly to DONE, the PAD state and pad_q are removed, fence_t_pad_i is ignored, and overrun_o is tied to 0.

Structure
REQ-028 SHALL place FENCE_T_W=11, the bit-index localparams (IF=0, UNISSUED=1, ID=2, EX=3, DCACHE=4, ICACHE=5, TLB=6, BP=7, DLFSR=8, ILFSR=9, PLRU=10) and the enum fence_t_state_e in ariane_pkg.
REQ-029 SHALL implement the saturating elapsed-cycle counter as the single sub-module fence_t_pad_cnt.

Verification
REQ-030 SHALL verify: sel=0x001, pad=0, macro on, accept at cycle 0 -> fence_t_o=0x001 at cycle 1, done_o at cycle 2, overrun_o=0.
REQ-031 SHALL verify: sel=0x010, pad=10, ack at cycle 20 -> fence_t_o[4] high cycles 1-20, FLUSH at cycle 21 with strobes 0, done_o at cycle 22, overrun_o=1.
REQ-032 SHALL verify: sel=0x7EF, pad=10 -> one-cycle strobe 0x7EF at cycle 1, done_o at cycle 12, halt_o high cycles 1-12, overrun_o=0.
REQ-033 SHALL verify: valid held high through DONE -> second request is accepted only in the IDLE cycle after done_o.
REQ-034 SHALL verify: rst_i at cycle 5 during DCACHE with sel=0x010 -> all outputs 0 next cycle, ready=1, a later ack causes no activity.
REQ-035 SHALL verify: macro off, sel=0x001, pad=100 -> done_o at cycle 2, overrun_o=0.

Source files
------------

// File: rtl/ariane_pkg.sv
// Shared fence.t definitions: strobe width, per-resource bit indices and sequencer states.
package ariane_pkg;

  localparam int unsigned FENCE_T_W = 11;

  localparam int unsigned IF       = 0;
  localparam int unsigned UNISSUED = 1;
  localparam int unsigned ID       = 2;
  localparam int unsigned EX       = 3;
  localparam int unsigned DCACHE   = 4;
  localparam int unsigned ICACHE   = 5;
  localparam int unsigned TLB      = 6;
  localparam int unsigned BP       = 7;
  localparam int unsigned DLFSR    = 8;
  localparam int unsigned ILFSR    = 9;
  localparam int unsigned PLRU     = 10;

  // State names carry an FT_ prefix so they do not collide with the bit indices above.
  typedef enum logic [2:0] {
    FT_IDLE   = 3'd0,
    FT_DCACHE = 3'd1,
    FT_FLUSH  = 3'd2,
    FT_PAD    = 3'd3,
    FT_DONE   = 3'd4
  } fence_t_state_e;

endpackage

// File: rtl/fence_t_pad_cnt.sv
// Saturating elapsed-cycle counter for the fence.t sequencer.
module fence_t_pad_cnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (en_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + Width'(1);
    end
  end

endmodule

// File: rtl/fence_t_sequencer.sv
// fence.t sequencer: DCache flush, one-cycle resource strobes, constant-time padding.
// Padding (PAD state, pad target, overrun flag) is built only when FENCE_T_PAD_EN is defined.
module fence_t_sequencer
  import ariane_pkg::*;
#(
  parameter int unsigned PadCntWidth = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   fence_t_valid_i,
  output logic                   fence_t_ready_o,
  input  logic [FENCE_T_W-1:0]   fence_t_sel_i,
  input  logic [PadCntWidth-1:0] fence_t_pad_i,
  input  logic                   flush_dcache_ack_i,
  output logic [FENCE_T_W-1:0]   fence_t_o,
  output logic                   halt_o,
  output logic                   done_o,
  output logic                   overrun_o
);

  fence_t_state_e         state_q, state_d;
  logic [FENCE_T_W-1:0]   sel_q;
  logic [PadCntWidth-1:0] cnt_q;
  logic                   accept;

  assign accept = fence_t_valid_i && (state_q == FT_IDLE);

  fence_t_pad_cnt #(
    .Width (PadCntWidth)
  ) i_pad_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (accept),
    .en_i  (state_q != FT_IDLE),
    .cnt_o (cnt_q)
  );

`ifdef FENCE_T_PAD_EN
  logic [PadCntWidth-1:0] pad_q;
  logic                   ovr_q;
  logic                   pad_done;

  assign pad_done = (cnt_q >= pad_q);
`else
  logic unused_pad;
  assign unused_pad = ^{fence_t_pad_i, cnt_q};
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FT_IDLE:   if (accept) state_d = fence_t_sel_i[DCACHE] ? FT_DCACHE : FT_FLUSH;
      FT_DCACHE: if (flush_dcache_ack_i) state_d = FT_FLUSH;
`ifdef FENCE_T_PAD_EN
      FT_FLUSH:  state_d = pad_done ? FT_DONE : FT_PAD;
      FT_PAD:    if (pad_done) state_d = FT_DONE;
`else
      FT_FLUSH:  state_d = FT_DONE;
      FT_PAD:    state_d = FT_DONE;
`endif
      FT_DONE:   state_d = FT_IDLE;
      default:   state_d = FT_IDLE;
    endcase
  end

  always_comb begin
    fence_t_o = '0;
    if (state_q == FT_DCACHE) begin
      fence_t_o[DCACHE] = 1'b1;
    end else if (state_q == FT_FLUSH) begin
      // DCache was already handled by its own state; never re-strobe it here.
      fence_t_o         = sel_q;
      fence_t_o[DCACHE] = 1'b0;
    end
  end

  assign fence_t_ready_o = (state_q == FT_IDLE);
  assign halt_o          = (state_q != FT_IDLE);
  assign done_o          = (state_q == FT_DONE);
`ifdef FENCE_T_PAD_EN
  assign overrun_o       = done_o && ovr_q;
`else
  assign overrun_o       = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FT_IDLE;
      sel_q   <= '0;
`ifdef FENCE_T_PAD_EN
      pad_q   <= '0;
      ovr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        sel_q <= fence_t_sel_i;
`ifdef FENCE_T_PAD_EN
        pad_q <= fence_t_pad_i;
`endif
      end
`ifdef FENCE_T_PAD_EN
      if (state_q == FT_FLUSH) ovr_q <= (cnt_q > pad_q);
`endif
    end
  end

endmodule

// File: tb/tb_fence_t_sequencer.sv
// Directed bench for fence_t_sequencer; expectations adapt to whether FENCE_T_PAD_EN is defined.
module tb_fence_t_sequencer;

  localparam int unsigned W = 11;
`ifdef FENCE_T_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_i;
  logic          fence_t_valid_i;
  logic          fence_t_ready_o;
  logic [W-1:0]  fence_t_sel_i;
  logic [15:0]   fence_t_pad_i;
  logic          flush_dcache_ack_i;
  logic [W-1:0]  fence_t_o;
  logic          halt_o;
  logic          done_o;
  logic          overrun_o;

  int checks = 0;
  int errors = 0;

  fence_t_sequencer #(
    .PadCntWidth (16)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .fence_t_valid_i    (fence_t_valid_i),
    .fence_t_ready_o    (fence_t_ready_o),
    .fence_t_sel_i      (fence_t_sel_i),
    .fence_t_pad_i      (fence_t_pad_i),
    .flush_dcache_ack_i (flush_dcache_ack_i),
    .fence_t_o          (fence_t_o),
    .halt_o             (halt_o),
    .done_o             (done_o),
    .overrun_o          (overrun_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_strb"}, 32'(fence_t_o), 32'h0);
    chk({tag, "_halt"}, 32'(halt_o), 32'h0);
    chk({tag, "_done"}, 32'(done_o), 32'h0);
    chk({tag, "_ovr"},  32'(overrun_o), 32'h0);
    chk({tag, "_rdy"},  32'(fence_t_ready_o), 32'h1);
  endtask

  // Accept at cycle 0; ack_c is the cycle the DCache ack is held high (0 = none).
  task automatic run_case(input string name, input logic [W-1:0] sel, input logic [15:0] pad,
                          input int ack_c, input int flush_c, input int done_c, input logic exp_ovr);
    logic [W-1:0] exp_strb;
    fence_t_sel_i   = sel;
    fence_t_pad_i   = pad;
    fence_t_valid_i = 1'b1;
    chk($sformatf("%s_c0_rdy", name), 32'(fence_t_ready_o), 32'h1);
    for (int c = 1; c <= done_c + 1; c++) begin
      step();
      if (c == 1) fence_t_valid_i = 1'b0;
      if (sel[4] && c <= ack_c)  exp_strb = 11'h010;
      else if (c == flush_c)     exp_strb = sel & 11'h7EF;
      else                       exp_strb = '0;
      chk($sformatf("%s_c%0d_strb", name, c), 32'(fence_t_o), 32'(exp_strb));
      chk($sformatf("%s_c%0d_halt", name, c), 32'(halt_o), 32'(c <= done_c));
      chk($sformatf("%s_c%0d_done", name, c), 32'(done_o), 32'(c == done_c));
      chk($sformatf("%s_c%0d_ovr", name, c), 32'(overrun_o), (c == done_c) ? 32'(exp_ovr) : 32'h0);
      chk($sformatf("%s_c%0d_rdy", name, c), 32'(fence_t_ready_o), 32'(c > done_c));
      flush_dcache_ack_i = (c == ack_c);
    end
    flush_dcache_ack_i = 1'b0;
  endtask

  initial begin
    rst_i              = 1'b1;
    fence_t_valid_i    = 1'b0;
    fence_t_sel_i      = '0;
    fence_t_pad_i      = '0;
    flush_dcache_ack_i = 1'b0;
    #1;
    chk_idle("reset");
    step();
    step();
    rst_i = 1'b0;
    step();
    chk_idle("post_reset");

    // Single strobe, no padding.
    run_case("sel001", 11'h001, 16'd0, 0, 1, 2, 1'b0);
    // DCache flush that outlasts the padding target.
    run_case("dcache", 11'h010, 16'd10, 20, 21, 22, PAD_ON);
    // Everything but DCache, padded to cnt=10.
    run_case("sel7ef", 11'h7EF, 16'd10, 0, 1, PAD_ON ? 12 : 2, 1'b0);
    // Large pad target; only matters with padding built in.
    run_case("pad100", 11'h001, 16'd100, 0, 1, PAD_ON ? 102 : 2, 1'b0);
    // Empty selection still walks the full path.
    run_case("sel000", 11'h000, 16'd3, 0, 1, PAD_ON ? 5 : 2, 1'b0);

    // Valid held high through DONE: no re-accept until the following IDLE cycle.
    fence_t_sel_i   = 11'h001;
    fence_t_pad_i   = 16'd0;
    fence_t_valid_i = 1'b1;
    step();
    chk("hold_c1_rdy",  32'(fence_t_ready_o), 32'h0);
    chk("hold_c1_strb", 32'(fence_t_o), 32'h001);
    step();
    chk("hold_c2_done", 32'(done_o), 32'h1);
    chk("hold_c2_rdy",  32'(fence_t_ready_o), 32'h0);
    step();
    chk("hold_c3_rdy",  32'(fence_t_ready_o), 32'h1);
    chk("hold_c3_strb", 32'(fence_t_o), 32'h0);
    chk("hold_c3_halt", 32'(halt_o), 32'h0);
    step();
    fence_t_valid_i = 1'b0;
    chk("hold_c4_strb", 32'(fence_t_o), 32'h001);
    step();
    chk("hold_c5_done", 32'(done_o), 32'h1);
    step();
    chk_idle("hold_c6");

    // Reset in the middle of a DCache flush, then a stray ack.
    fence_t_sel_i   = 11'h010;
    fence_t_pad_i   = 16'd10;
    fence_t_valid_i = 1'b1;
    step();
    fence_t_valid_i = 1'b0;
    chk("rst_c1_strb", 32'(fence_t_o), 32'h010);
    for (int c = 2; c <= 5; c++) step();
    chk("rst_c5_halt", 32'(halt_o), 32'h1);
    chk("rst_c5_strb", 32'(fence_t_o), 32'h010);
    rst_i = 1'b1;
    #1;
    chk_idle("rst_async");
    step();
    rst_i = 1'b0;
    flush_dcache_ack_i = 1'b1;
    step();
    flush_dcache_ack_i = 1'b0;
    chk_idle("late_ack_c1");
    step();
    chk_idle("late_ack_c2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
